// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops, iterative shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic [WIDTH-1:0] op2_x;
   logic [WIDTH:0]   addsub;
   logic             big_sh;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] fast_res;
   logic             fast_c, fast_v;

   logic [WIDTH:0]   mul_add;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             div_ge;
   logic [WIDTH:0]   acc_nx;
   logic [WIDTH-1:0] lo_nx;
   logic [WIDTH-1:0] iter_res;

   logic             accept;
   logic             is_iter;

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign flags     = flags_q;

   assign accept  = in_valid && in_ready;
   assign is_iter = alu_control[3] && !alu_control[2];

   always_comb begin
      op2_x    = alu_control[0] ? ~op2 : op2;
      addsub   = {1'b0, op1} + {1'b0, op2_x} + {{WIDTH{1'b0}}, alu_control[0]};
      // Any bit set above the shift index range means amount >= WIDTH.
      big_sh   = |(op2 >> SHW);
      sh       = op2[SHW-1:0];
      fast_res = '0;
      fast_c   = 1'b0;
      fast_v   = 1'b0;
      case (alu_control)
         4'b0000, 4'b0001: begin
            fast_res = addsub[WIDTH-1:0];
            fast_c   = addsub[WIDTH];
            fast_v   = ~(alu_control[0] ^ op1[WIDTH-1] ^ op2[WIDTH-1])
                       & (op1[WIDTH-1] ^ addsub[WIDTH-1]);
         end
         4'b0010: fast_res = op1 & op2;
         4'b0011: fast_res = op1 | op2;
         4'b0100: fast_res = op1 ^ op2;
         4'b0101: fast_res = big_sh ? '0 : (op1 << sh);
         4'b0110: fast_res = big_sh ? '0 : (op1 >> sh);
         4'b0111: fast_res = big_sh ? {WIDTH{op1[WIDTH-1]}}
                                    : $unsigned($signed(op1) >>> sh);
         default: fast_res = '0;
      endcase
   end

   // acc holds product-high / partial remainder, lo holds multiplier / quotient.
   always_comb begin
      mul_add   = lo_q[0] ? (acc_q + {1'b0, opb_q}) : acc_q;
      div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      div_ge    = (div_shift >= {1'b0, opb_q});
      if (ctrl_q[1]) begin
         acc_nx = div_ge ? div_diff : div_shift;
         lo_nx  = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         acc_nx = {1'b0, mul_add[WIDTH:1]};
         lo_nx  = {mul_add[0], lo_q[WIDTH-1:1]};
      end
      iter_res = ctrl_q[0] ? acc_nx[WIDTH-1:0] : lo_nx;
   end

   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_iter) begin
                  state_d = S_BUSY;
                  ctrl_d  = alu_control[1:0];
                  opb_d   = op2;
                  lo_d    = op1;
                  acc_d   = '0;
                  cnt_d   = '0;
               end else begin
                  state_d  = S_DONE;
                  result_d = fast_res;
                  flags_d  = {fast_res[WIDTH-1], fast_res == '0, fast_c, fast_v};
               end
            end
         end
         S_BUSY: begin
            acc_d = acc_nx;
            lo_d  = lo_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               state_d  = S_DONE;
               result_d = iter_res;
               flags_d  = {iter_res[WIDTH-1], iter_res == '0, 1'b0, 1'b0};
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ctrl_q   <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (WIDTH = 32) with immediate-assertion checks.
module tb_alu_mc;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op1, op2;
   logic [3:0]   alu_control;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op1         (op1),
      .op2         (op2),
      .alu_control (alu_control),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .flags       (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, wait for the result with a bounded budget, check it, then drain.
   task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_r,
                         input logic [3:0] exp_f, input int exp_lat);
      int lat;
      int busy;
      chk({tag, "_ready_before"}, in_ready, 1);
      in_valid    = 1'b1;
      op1         = a;
      op2         = b;
      alu_control = ctrl;
      step();
      in_valid    = 1'b0;
      op1         = ~a;
      op2         = b ^ 32'h1234_5678;
      alu_control = ~ctrl;
      lat  = 1;
      busy = 0;
      while (!out_valid && lat < 100) begin
         if (!in_ready) busy++;
         step();
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_busy_cycles"}, busy, exp_lat - 1);
      chk({tag, "_result"}, result, exp_r);
      chk({tag, "_flags"}, flags, exp_f);
      chk({tag, "_ready_in_done"}, in_ready, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_valid_after_drain"}, out_valid, 0);
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b1;
      out_ready   = 1'b0;
      op1         = 32'd3;
      op2         = 32'd4;
      alu_control = 4'b0000;
      step();
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_result", result, 0);
      chk("reset_flags", flags, 0);
      chk("reset_in_ready", in_ready, 1);
      step();
      chk("reset_no_accept", out_valid, 0);

      run_op("sum_ovf",   4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 1);
      run_op("sum_carry", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1);
      run_op("dif_zero",  4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110, 1);
      run_op("dif_neg",   4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000, 1);
      run_op("dif_ovf",   4'b0001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011, 1);
      run_op("and",       4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000, 1);
      run_op("orr_zero",  4'b0011, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100, 1);
      run_op("xor",       4'b0100, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 4'b1000, 1);
      run_op("sll_31",    4'b0101, 32'h0000_0001, 32'd31,        32'h8000_0000, 4'b1000, 1);
      run_op("sll_32",    4'b0101, 32'h0000_0001, 32'd32,        32'h0000_0000, 4'b0100, 1);
      run_op("slr_4",     4'b0110, 32'h8000_0000, 32'd4,         32'h0800_0000, 4'b0000, 1);
      run_op("slr_big",   4'b0110, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0000, 4'b0100, 1);
      run_op("sar_40",    4'b0111, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF, 4'b1000, 1);
      run_op("sar_4",     4'b0111, 32'h8000_0000, 32'd4,         32'hF800_0000, 4'b1000, 1);
      run_op("op_1100",   4'b1100, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 4'b0100, 1);
      run_op("op_1111",   4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100, 1);

      run_op("mulhu_max", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1000, 33);
      run_op("mul_max",   4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 33);
      run_op("mul_dec",   4'b1000, 32'd12345,     32'd1000,      32'h00BC_5EA8, 4'b0000, 33);
      run_op("mulhu_sm",  4'b1001, 32'd12345,     32'd1000,      32'h0000_0000, 4'b0100, 33);
      run_op("divu",      4'b1010, 32'd100,       32'd7,         32'd14,        4'b0000, 33);
      run_op("remu",      4'b1011, 32'd100,       32'd7,         32'd2,         4'b0000, 33);
      run_op("divu_z",    4'b1010, 32'd5,         32'd0,         32'hFFFF_FFFF, 4'b1000, 33);
      run_op("remu_z",    4'b1011, 32'd5,         32'd0,         32'd5,         4'b0000, 33);
      run_op("remu_exact",4'b1011, 32'd6,         32'd3,         32'd0,         4'b0100, 33);

      // Hold in DONE with out_ready low; then a request arriving with out_ready waits one edge.
      in_valid    = 1'b1;
      op1         = 32'd3;
      op2         = 32'd4;
      alu_control = 4'b0000;
      step();
      in_valid = 1'b0;
      chk("hold_valid_start", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("hold_result", result, 32'd7);
         chk("hold_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
      end
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      op1         = 32'd10;
      op2         = 32'd20;
      alu_control = 4'b0000;
      chk("b2b_ready_in_done", in_ready, 0);
      step();
      out_ready = 1'b0;
      chk("b2b_not_accepted", out_valid, 0);
      chk("b2b_ready_idle", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("b2b_second_valid", out_valid, 1);
      chk("b2b_second_result", result, 32'd30);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Reset in the middle of a multiply discards it.
      in_valid    = 1'b1;
      op1         = 32'hFFFF_FFFF;
      op2         = 32'hFFFF_FFFF;
      alu_control = 4'b1000;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("midbusy_in_ready", in_ready, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_result", result, 0);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            step();
         end
         chk("midrst_no_valid", seen, 0);
      end

      run_op("post_rst_sum", 4'b0000, 32'd1, 32'd2, 32'd3, 4'b0000, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal >= 4, power of two).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 op1  input  WIDTH  first operand.
REQ-007 op2  input  WIDTH  second operand or shift amount.
REQ-008 alu_control  input  4  operation code, encoding in REQ-014.
REQ-009 out_valid  output  1  result and flags are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 flags  output  4  registered {negative, zero, carry, overflow}.

Function
REQ-013 Request accepted on the rising edge where in_valid && in_ready; op1, op2 and alu_control are captured at that edge, and later input changes have no effect.
REQ-014 Encoding: 0000 SUM, 0001 DIF, 0010 AND, 0011 ORR, 0100 XOR, 0101 SLL, 0110 SLR, 0111 SAR, 1000 MUL (low WIDTH bits), 1001 MULHU (high WIDTH bits, unsigned), 1010 DIVU, 1011 REMU; 1100-1111 give result 0 and flags {0,1,0,0}.
REQ-015 SUM/DIF: result = op1 + (op2 or ~op2) + alu_control[0]; carry = bit WIDTH of the (WIDTH+1)-bit sum; overflow = ~(alu_control[0]^op1[MSB]^op2[MSB]) & (op1[MSB]^result[MSB]).
REQ-016 Shifts use the full op2 value: amount >= WIDTH gives 0 for SLL/SLR and WIDTH copies of op1[MSB] for SAR.
REQ-017 negative = result[WIDTH-1] and zero = (result == 0) for every op; carry = overflow = 0 for every op except SUM/DIF.
REQ-018 FSM states: IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-019 IDLE + accept of ops 0000-0111 or 1100-1111 -> DONE next edge (latency 1: out_valid high the cycle after acceptance).
REQ-020 IDLE + accept of ops 1000-1011 -> BUSY; iterate one bit per cycle for exactly WIDTH cycles, then -> DONE (out_valid high WIDTH+1 cycles after acceptance).
REQ-021 MUL/MULHU: iterative unsigned shift-add producing a 2*WIDTH-bit product; select the low or high half.
REQ-022 DIVU/REMU: iterative unsigned restoring division; select the quotient or remainder.
REQ-023 Divide by zero: DIVU result = all ones, REMU result = op1, no extra cycles, no error signal.
REQ-024 DONE: out_valid = 1 and result/flags are held stable until out_ready is sampled high; that edge -> IDLE.
REQ-025 out_valid && out_ready in DONE with in_valid high: the new request is not accepted that cycle (in_ready = 0); it is accepted at the earliest on the next edge.
REQ-026 out_ready is ignored outside DONE; in_valid is ignored outside IDLE.
REQ-027 The block holds at most one operation in flight; there is no queueing.

Reset
REQ-028 rst high at an edge: state -> IDLE, out_valid = 0, result = 0, flags = 0, iteration counter = 0, in_ready = 1 from the following cycle.
REQ-029 Reset mid-operation (BUSY or DONE) discards the operation; no out_valid is produced for it.
REQ-030 A request presented while rst is high is not accepted.

Verification (WIDTH = 32)
REQ-031 SUM 0x7FFFFFFF + 0x00000001, out_ready = 1 -> out_valid 1 cycle later, result 0x80000000, flags 1001.
REQ-032 DIF 0x00000005 - 0x00000005 -> result 0, flags 0110; SAR 0x80000000 by 40 -> result 0xFFFFFFFF, flags 1000.
REQ-033 MULHU 0xFFFFFFFF * 0xFFFFFFFF -> in_ready low for 32 cycles, out_valid at cycle 33, result 0xFFFFFFFE; MUL of the same operands -> 0x00000001.
REQ-034 DIVU 100 / 7 -> 14 and REMU -> 2, both at latency 33; DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
REQ-035 out_ready held low 10 cycles in DONE -> result stable and in_ready low throughout; rst asserted mid-BUSY -> out_valid never rises and in_ready = 1 the cycle after.
